// File: rtl/ir_scan_ctrl.sv
// IR guardrail/line sensor scan controller: strobes the emitter, samples after settle, debounces across scans.
// Optional sticky guardrail flag enabled by defining IR_GUARD_LATCH_EN.
module ir_scan_ctrl #(
    parameter int FAST_SIM   = 1,
    parameter int SETTLE_CYC = 256,
    parameter int OFF_CYC    = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic lftIR_n,
    input  logic rghtIR_n,
    input  logic cntrIR_n,
    input  logic clr_guard,
    output logic IR_en,
    output logic lftIR,
    output logic rghtIR,
    output logic cntrIR,
    output logic scan_done,
    output logic guard_hit
);
    localparam int DIV        = (FAST_SIM != 0) ? 16 : 1;
    localparam int SETTLE_EFF = SETTLE_CYC / DIV;
    localparam int OFF_EFF    = OFF_CYC / DIV;
    localparam int MAX_EFF    = (SETTLE_EFF > OFF_EFF) ? SETTLE_EFF : OFF_EFF;
    localparam int CNT_W      = (MAX_EFF > 1) ? $clog2(MAX_EFF) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(OFF_EFF - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ir_en_q, done_q, cpulse_q;
    // Channel bit order: [0]=left, [1]=right, [2]=centre
    logic [2:0]       sync1_q, sync2_q, samp;
    logic [2:0]       lvl_q, lvl_d, hist_q, agree;
    logic             cpulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {cntrIR_n, rghtIR_n, lftIR_n};
            sync2_q <= sync1_q;
        end
    end

    assign samp = ~sync2_q;

    // A level only moves when two consecutive captures agree.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        agree    = ~(samp ^ hist_q);
        lvl_d    = (agree & samp) | (~agree & lvl_q);
        cpulse_d = lvl_d[2] & ~lvl_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ir_en_q  <= 1'b0;
            done_q   <= 1'b0;
            cpulse_q <= 1'b0;
            lvl_q    <= '0;
            hist_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            cpulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= ON;
                        cnt_q   <= '0;
                        ir_en_q <= 1'b1;
                    end
                end
                ON, OFF: begin
                    if (!en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ir_en_q <= 1'b0;
                        lvl_q   <= '0;
                        hist_q  <= '0;
                    end else if (state_q == ON) begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_q  <= OFF;
                            cnt_q    <= '0;
                            ir_en_q  <= 1'b0;
                            done_q   <= 1'b1;
                            cpulse_q <= cpulse_d;
                            lvl_q    <= lvl_d;
                            hist_q   <= samp;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        if (cnt_q == OFF_LAST) begin
                            state_q <= ON;
                            cnt_q   <= '0;
                            ir_en_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ir_en_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IR_GUARD_LATCH_EN
    logic guard_q;
    // Set has priority over clear; en dropping does not touch the flag.
    always_ff @(posedge clk) begin
        if (rst)
            guard_q <= 1'b0;
        else if (lvl_q[0] | lvl_q[1])
            guard_q <= 1'b1;
        else if (clr_guard)
            guard_q <= 1'b0;
    end
    assign guard_hit = guard_q;
`else
    logic unused_clr_guard;
    assign unused_clr_guard = clr_guard;
    assign guard_hit = 1'b0;
`endif

    assign IR_en     = ir_en_q;
    assign lftIR     = lvl_q[0];
    assign rghtIR    = lvl_q[1];
    assign cntrIR    = cpulse_q;
    assign scan_done = done_q;
endmodule

// File: tb/tb_ir_scan_ctrl.sv
// Directed bench for ir_scan_ctrl at FAST_SIM=1 (settle 16, off 256 cycles).
module tb_ir_scan_ctrl;
    logic clk = 1'b0;
    logic rst, en, lftIR_n, rghtIR_n, cntrIR_n, clr_guard;
    logic IR_en, lftIR, rghtIR, cntrIR, scan_done, guard_hit;
    int total = 0;
    int bad   = 0;

`ifdef IR_GUARD_LATCH_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    ir_scan_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .lftIR_n(lftIR_n), .rghtIR_n(rghtIR_n), .cntrIR_n(cntrIR_n),
        .clr_guard(clr_guard),
        .IR_en(IR_en), .lftIR(lftIR), .rghtIR(rghtIR), .cntrIR(cntrIR),
        .scan_done(scan_done), .guard_hit(guard_hit)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to the next cycle showing scan_done, counting centre pulses on the way.
    task automatic wait_scan(output int cyc, output int cp);
        cyc = 0;
        cp  = 0;
        do begin
            tick(1);
            cyc++;
            if (cntrIR === 1'b1) cp++;
        end while (scan_done !== 1'b1 && cyc < 600);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr_guard = 1'b0;
        lftIR_n = 1'b1; rghtIR_n = 1'b1; cntrIR_n = 1'b1;
        tick(2);
        total++;
        if ({IR_en, lftIR, rghtIR, cntrIR, scan_done, guard_hit} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {IR_en, lftIR, rghtIR, cntrIR, scan_done, guard_hit});
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_enable();
        int hi, lo, sd;
        en = 1'b1;
        tick(1);
        total++;
        if (IR_en !== 1'b1) begin bad++; $display("FAIL enable_rise got=%b exp=1", IR_en); end
        hi = 0;
        while (IR_en === 1'b1 && hi < 100) begin hi++; tick(1); end
        total++;
        if (hi !== 16 || scan_done !== 1'b1) begin
            bad++; $display("FAIL on_width got=%0d/sd=%b exp=16/sd=1", hi, scan_done);
        end
        lo = 0; sd = 0;
        while (IR_en === 1'b0 && lo < 1000) begin
            if (scan_done === 1'b1) sd++;
            lo++;
            tick(1);
        end
        total++;
        if (lo !== 256 || sd !== 1) begin
            bad++; $display("FAIL off_width got=%0d/pulses=%0d exp=256/1", lo, sd);
        end
    endtask

    task automatic test_debounce();
        logic [3:0] lin [4];
        logic [3:0] lexp[4];
        int cyc, cp;
        lin  = '{4'd0, 4'd1, 4'd0, 4'd0};
        lexp = '{4'd0, 4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 4; i++) begin
            lftIR_n = lin[i][0];
            wait_scan(cyc, cp);
            total++;
            if ({scan_done, lftIR, rghtIR} !== {1'b1, lexp[i][0], 1'b0}) begin
                bad++;
                $display("FAIL debounce_scan%0d got sd/l/r=%b exp=1%b0", i,
                         {scan_done, lftIR, rghtIR}, lexp[i][0]);
            end
        end
    endtask

    task automatic test_centre();
        logic [1:0] cin[7];
        int         pexp[7];
        int cyc, cp;
        cin  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        pexp = '{0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            cntrIR_n = cin[i][0];
            wait_scan(cyc, cp);
            total++;
            if (scan_done !== 1'b1 || cp !== pexp[i]) begin
                bad++;
                $display("FAIL centre_scan%0d got sd=%b pulses=%0d exp sd=1 pulses=%0d",
                         i, scan_done, cp, pexp[i]);
            end
        end
    endtask

    task automatic test_abort();
        int n, sd, ir;
        n = 0;
        while (IR_en !== 1'b1 && n < 400) begin tick(1); n++; end
        total++;
        if ({IR_en, lftIR} !== 2'b11) begin
            bad++; $display("FAIL abort_pre got en/l=%b exp=11", {IR_en, lftIR});
        end
        tick(8);
        en = 1'b0;
        tick(1);
        total++;
        if ({IR_en, lftIR, scan_done} !== 3'b000) begin
            bad++; $display("FAIL abort_now got en/l/sd=%b exp=000", {IR_en, lftIR, scan_done});
        end
        sd = 0; ir = 0;
        repeat (30) begin
            tick(1);
            if (scan_done === 1'b1) sd++;
            if (IR_en === 1'b1) ir++;
        end
        total++;
        if (sd !== 0 || ir !== 0) begin
            bad++; $display("FAIL abort_idle got sd=%0d ir=%0d exp 0 0", sd, ir);
        end
    endtask

    task automatic test_sync_reset();
        int cyc, cp;
        lftIR_n = 1'b1; cntrIR_n = 1'b1; rghtIR_n = 1'b0;
        en = 1'b1;
        wait_scan(cyc, cp);
        total++;
        if ({scan_done, rghtIR} !== 2'b10) begin
            bad++; $display("FAIL hist_after_abort got sd/r=%b exp=10", {scan_done, rghtIR});
        end
        wait_scan(cyc, cp);
        total++;
        if ({scan_done, rghtIR, lftIR} !== 3'b110) begin
            bad++; $display("FAIL right_level got sd/r/l=%b exp=110", {scan_done, rghtIR, lftIR});
        end
        tick(2);
        total++;
        if (guard_hit !== GUARD) begin
            bad++; $display("FAIL guard_set got=%b exp=%b", guard_hit, GUARD);
        end
        tick(20);
        rst = 1'b1;
        tick(1);
        total++;
        if ({IR_en, lftIR, rghtIR, cntrIR, scan_done, guard_hit} !== 6'b0) begin
            bad++;
            $display("FAIL midscan_reset got=%b exp=000000",
                     {IR_en, lftIR, rghtIR, cntrIR, scan_done, guard_hit});
        end
        rst = 1'b0;
        tick(1);
        total++;
        if (IR_en !== 1'b1) begin bad++; $display("FAIL restart_rise got=%b exp=1", IR_en); end
        wait_scan(cyc, cp);
        total++;
        if (cyc !== 16 || scan_done !== 1'b1 || rghtIR !== 1'b0) begin
            bad++;
            $display("FAIL restart_scan got cyc=%0d sd=%b r=%b exp cyc=16 sd=1 r=0",
                     cyc, scan_done, rghtIR);
        end
    endtask

    task automatic test_guard();
        int cyc, cp;
        wait_scan(cyc, cp);
        tick(1);
        total++;
        if ({rghtIR, guard_hit} !== {1'b1, GUARD}) begin
            bad++; $display("FAIL guard_on got r/g=%b exp=1%b", {rghtIR, guard_hit}, GUARD);
        end
        rghtIR_n = 1'b1;
        wait_scan(cyc, cp);
        wait_scan(cyc, cp);
        total++;
        if ({rghtIR, guard_hit} !== {1'b0, GUARD}) begin
            bad++; $display("FAIL guard_sticky got r/g=%b exp=0%b", {rghtIR, guard_hit}, GUARD);
        end
        clr_guard = 1'b1;
        tick(1);
        clr_guard = 1'b0;
        tick(1);
        total++;
        if (guard_hit !== 1'b0) begin bad++; $display("FAIL guard_clear got=%b exp=0", guard_hit); end
        rghtIR_n = 1'b0;
        wait_scan(cyc, cp);
        wait_scan(cyc, cp);
        clr_guard = 1'b1;
        tick(3);
        total++;
        if ({rghtIR, guard_hit} !== {1'b1, GUARD}) begin
            bad++; $display("FAIL guard_set_wins got r/g=%b exp=1%b", {rghtIR, guard_hit}, GUARD);
        end
        clr_guard = 1'b0;
        en = 1'b0;
        tick(2);
        total++;
        if ({IR_en, rghtIR, guard_hit} !== {2'b00, GUARD}) begin
            bad++;
            $display("FAIL guard_after_en_low got en/r/g=%b exp=00%b", {IR_en, rghtIR, guard_hit}, GUARD);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_debounce();
        test_centre();
        test_abort();
        test_sync_reset();
        test_guard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ir_scan_ctrl.md
Name: ir_scan_ctrl

Overview:
Sequences the knight's IR guardrail/line sensors. Strobes the emitter (IR_en) periodically, samples the three active-low receivers after a settle window, and debounces each sample across scans. Outputs debounced lftIR/rghtIR levels and a one-cycle cntrIR crossing pulse to cmd_proc/inertial_integrator inside KnightsTour.
- Reduces emitter duty cycle (power).
- Rejects single-scan glitches that would otherwise appear as guardrail hits during straight moves.

Parameters:
FAST_SIM, 1, when 1 the effective SETTLE_CYC and OFF_CYC are each divided by 16 (simulation only)
SETTLE_CYC, 256, cycles IR_en is held high before sampling (effective, FAST_SIM=1: 16)
OFF_CYC, 4096, cycles IR_en is held low between scans (effective, FAST_SIM=1: 256)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable from cmd_proc (high while a move is in progress)
lftIR_n  input  1  left receiver, active-low, asynchronous
rghtIR_n  input  1  right receiver, active-low, asynchronous
cntrIR_n  input  1  centre receiver, active-low, asynchronous
clr_guard  input  1  clears sticky guard flag (used only with the optional feature)
IR_en  output  1  emitter enable
lftIR  output  1  debounced left guardrail level
rghtIR  output  1  debounced right guardrail level
cntrIR  output  1  one-cycle pulse on debounced centre 0->1 transition
scan_done  output  1  one-cycle pulse when a sample is captured
guard_hit  output  1  sticky guardrail flag (optional feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0, sync flops 1 (inactive), sample history 0. Reset has priority over every other input, including mid-scan.
- Synchroniser: each *_n input passes through two flops, then is inverted to active-high s_l, s_r, s_c.
- FSM states: IDLE, ON, OFF. IR_en is registered and equals (state==ON).
- IDLE: when en=1, go to ON with counter=0. IR_en rises on the following cycle.
- ON:
  - Increment counter each cycle.
  - When counter==SETTLE_eff-1: capture s_l/s_r/s_c, pulse scan_done for 1 cycle, clear counter, go to OFF.
  - IR_en is high for exactly SETTLE_eff cycles.
- OFF:
  - Increment counter each cycle.
  - When counter==OFF_eff-1: clear counter; go to ON if en=1, otherwise go to IDLE.
  - Full period = SETTLE_eff+OFF_eff cycles (272 with FAST_SIM=1).
- en low in ON or OFF: abort next cycle to IDLE.
  - IR_en=0, counter cleared.
  - lftIR/rghtIR/cntr level and history cleared to 0.
  - No scan_done or cntrIR pulse is produced.
- Debounce (per channel, on each capture): new sample s, previous sample p.
  - If s==p, level<=s; otherwise level holds.
  - p<=s on every capture.
  - Net effect: a level change needs 2 consecutive agreeing scans.
- Output timing:
  - lftIR/rghtIR update in the same cycle scan_done is high (registered, visible the cycle after capture).
  - cntrIR pulses in that same cycle if the centre level goes 0->1.
  - A falling centre level produces no pulse.
- Counter width is clog2(max(SETTLE_eff, OFF_eff)). Counters do not wrap beyond their terminal value.

Optional Feature:
Macro IR_GUARD_LATCH_EN.
- Defined:
  - guard_hit sets on any cycle where debounced lftIR or rghtIR is 1.
  - guard_hit stays set until clr_guard=1 or rst.
  - If set and clear occur in the same cycle, set wins.
  - guard_hit is not cleared by en going low.
- Undefined: guard_hit is tied 0 and clr_guard is ignored.

Test Plan:
- Reset and enable: rst=1 for 2 cycles, then en=1 (FAST_SIM=1) -> IR_en high 16 cycles, low 256 cycles, repeating. scan_done pulses every 272 cycles, 16 cycles after each IR_en rise.
- Guardrail debounce: lftIR_n=0 for one scan only -> lftIR stays 0. lftIR_n=0 for two consecutive scans -> lftIR=1 after the second scan_done; rghtIR stays 0 throughout.
- Centre crossing: cntrIR_n=0 held for 3 scans -> exactly one cntrIR pulse, at the second scan_done. Release for 2 scans, then reassert for 2 scans -> a second single pulse.
- Abort: drop en at cycle 8 of ON with lftIR=1 -> IR_en=0 next cycle, lftIR=0, state IDLE, no scan_done.
- Sync reset mid-scan: rst=1 in OFF with rghtIR=1 -> all outputs 0 on the next clk edge. With en=1, the scan restarts from ON after rst deasserts.
- IR_GUARD_LATCH_EN: rghtIR asserted 2 scans then released -> guard_hit stays 1. clr_guard pulse -> 0. Without the macro, guard_hit stays 0 throughout.
